// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM states and the default operand width.
package serial_sub_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/full_sub1.sv
// One-bit full subtractor: d = a - b - bin, bout set when the bit position needs a borrow.
module full_sub1 (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_sub4.sv
// Bit-serial subtractor: d = a - b - bi computed LSB first, one bit per clock,
// through a single full subtractor and a borrow register.
module serial_sub4
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bi,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] d,
    output logic             bo
);

    localparam int CW = $clog2(WIDTH) + 1;

    // Handshakes: a transfer happens on a rising edge where valid & ready are both high.
    // in_ready is high only in IDLE and out_valid only in DONE, so one operation is in flight at a time.
    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic             brw;
    logic [CW-1:0]    cnt;
    logic             diff_bit;
    logic             brw_next;
    logic             accept;
    logic             take;
    logic             last_bit;

    full_sub1 u_bit (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .bin  (brw),
        .d    (diff_bit),
        .bout (brw_next)
    );

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign accept    = in_valid & in_ready;
    assign take      = out_valid & out_ready;
    assign last_bit  = (cnt == CW'(WIDTH - 1));

    // Result is gated by state so partial differences never leak out.
    assign d  = out_valid ? res_sr : '0;
    assign bo = out_valid & brw;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept)   state_next = RUN;
            RUN:     if (last_bit) state_next = DONE;
            DONE:    if (take)     state_next = IDLE;
            default:               state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            brw    <= 1'b0;
            cnt    <= '0;
        end else if (accept) begin
            a_sr   <= a;
            b_sr   <= b;
            res_sr <= '0;
            brw    <= bi;
            cnt    <= '0;
        end else if (state == RUN) begin
            a_sr   <= a_sr >> 1;
            b_sr   <= b_sr >> 1;
            res_sr <= {diff_bit, res_sr[WIDTH-1:1]};
            brw    <= brw_next;
            cnt    <= cnt + CW'(1);
        end
    end

endmodule

// File: tb/tb_serial_sub4.sv
// Bench for serial_sub4: directed vector table, hand-written backpressure/reset sequences,
// and an exhaustive shuffled sweep checked against an arithmetic reference model.
module tb_serial_sub4;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bi;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] d;
    logic         bo;

    int checks = 0;
    int errors = 0;
    logic [W:0] exp_q[$];

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         bi;
        logic [W-1:0] d;
        logic         bo;
    } vec_t;

    vec_t vecs[7];

    always #5 clk = ~clk;

    serial_sub4 #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bi        (bi),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .d         (d),
        .bo        (bo)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain signed arithmetic, packed as {borrow, difference}.
    function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        int diff;
        logic [31:0] dv;
        diff = int'(x) - int'(y) - int'(c);
        dv = diff;
        return {(diff < 0), dv[W-1:0]};
    endfunction

    task automatic do_op(input string tag, input logic [W-1:0] xa, input logic [W-1:0] xb,
                         input logic xbi, input logic [W-1:0] ed, input logic ebo);
        int n;
        int leak;
        @(negedge clk);
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check({tag, " in_ready"}, in_ready, 1);
        a = xa; b = xb; bi = xbi; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        leak = 0;
        while (!out_valid && n < 50) begin
            if (d !== '0 || bo !== 1'b0 || in_ready !== 1'b0) leak++;
            @(negedge clk);
            n++;
        end
        check({tag, " latency"}, n, W);
        check({tag, " partial"}, leak, 0);
        check({tag, " d"}, d, ed);
        check({tag, " bo"}, bo, ebo);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, " post out_valid"}, out_valid, 0);
        check({tag, " post in_ready"}, in_ready, 1);
    endtask

    initial begin
        int n;
        int ord[512];
        int idx;
        int got;
        int gap;
        int cyc;
        int extra;
        logic [W:0] e;

        vecs[0] = '{a: 4'd9,  b: 4'd3,  bi: 1'b0, d: 4'd6,  bo: 1'b0};
        vecs[1] = '{a: 4'd3,  b: 4'd9,  bi: 1'b0, d: 4'hA,  bo: 1'b1};
        vecs[2] = '{a: 4'd0,  b: 4'd0,  bi: 1'b1, d: 4'hF,  bo: 1'b1};
        vecs[3] = '{a: 4'd15, b: 4'd1,  bi: 1'b0, d: 4'd14, bo: 1'b0};
        vecs[4] = '{a: 4'd15, b: 4'd15, bi: 1'b1, d: 4'hF,  bo: 1'b1};
        vecs[5] = '{a: 4'd8,  b: 4'd7,  bi: 1'b1, d: 4'd0,  bo: 1'b0};
        vecs[6] = '{a: 4'd0,  b: 4'd15, bi: 1'b0, d: 4'd1,  bo: 1'b1};

        // Reset: outputs idle, and in_valid offered during reset must be ignored.
        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b0; a = 4'd1; b = 4'd0; bi = 1'b0;
        #2;
        check("reset in_ready", in_ready, 1);
        check("reset out_valid", out_valid, 0);
        check("reset d", d, 0);
        check("reset bo", bo, 0);
        @(negedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b0;
        check("after reset in_ready", in_ready, 1);

        for (int i = 0; i < 7; i++)
            do_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].bi, vecs[i].d, vecs[i].bo);

        // Backpressure in DONE with an in_valid pulse that must be ignored.
        @(negedge clk);
        a = 4'd5; b = 4'd5; bi = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("hold latency", n, W);
        for (int i = 0; i < 3; i++) begin
            check("hold out_valid", out_valid, 1);
            check("hold d", d, 0);
            check("hold bo", bo, 0);
            check("hold in_ready", in_ready, 0);
            if (i == 1) begin
                a = 4'd15; b = 4'd0; bi = 1'b1; in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("hold out_valid end", out_valid, 1);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("hold handshake out_valid", out_valid, 0);
        check("hold handshake in_ready", in_ready, 1);
        @(negedge clk);
        check("hold pulse ignored", in_ready, 1);

        // Reset mid-operation after two RUN edges.
        a = 4'd7; b = 4'd2; bi = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("abort running", in_ready, 0);
        #2 rst = 1'b1;
        #1;
        check("abort out_valid", out_valid, 0);
        check("abort in_ready", in_ready, 1);
        check("abort d", d, 0);
        in_valid = 1'b1; a = 4'd1;
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b0;
        check("abort no accept", in_ready, 1);
        check("abort no result", out_valid, 0);
        do_op("after abort", 4'd15, 4'd1, 1'b0, 4'd14, 1'b0);

        // Exhaustive sweep in shuffled order with random gaps and backpressure.
        for (int i = 0; i < 512; i++) ord[i] = i;
        for (int i = 511; i > 0; i--) begin
            int j;
            int t;
            j = $urandom_range(0, i);
            t = ord[i]; ord[i] = ord[j]; ord[j] = t;
        end
        idx = 0; got = 0; cyc = 0;
        gap = $urandom_range(0, 3);
        in_valid = 1'b0;
        while (got < 512 && cyc < 30000) begin
            @(negedge clk);
            cyc++;
            if (!in_valid && idx < 512) begin
                if (gap > 0) begin
                    gap--;
                end else begin
                    a  = ord[idx][8:5];
                    b  = ord[idx][4:1];
                    bi = ord[idx][0];
                    in_valid = 1'b1;
                end
            end
            out_ready = ($urandom_range(0, 2) != 0);
            if (in_valid && in_ready) begin
                exp_q.push_back(model(a, b, bi));
                idx++;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("sweep unexpected result", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("sweep result %0d", got), {bo, d}, e);
                end
                got++;
            end
            // Drop the offer after an accepting edge and pick a new gap.
            if (in_valid && in_ready) begin
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                gap = $urandom_range(0, 3);
            end
        end
        in_valid = 1'b0;
        check("sweep results", got, 512);
        check("sweep accepted", idx, 512);
        check("sweep queue empty", exp_q.size(), 0);
        out_ready = 1'b1;
        extra = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid) extra++;
        end
        out_ready = 1'b0;
        check("sweep no duplicates", extra, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
